// File: rtl/qmem_pkg.sv
// Shared definitions for the QMEM width bridge: FSM state encoding and a
// constant-foldable ceiling-log2 helper for deriving index widths.
package qmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_GAP  = 2'd2,
    ST_ACK  = 2'd3
  } qmem_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qmem_beat_sel.sv
// Next-beat finder for the width bridge. With QMEM_WB_SKIP_EN defined, beats
// whose byte-enable slice is all zero are passed over; otherwise every beat issues.
module qmem_beat_sel #(
  parameter int MSW = 4,
  parameter int SSW = 2,
  parameter int BW  = 1
) (
`ifdef QMEM_WB_SKIP_EN
  input  logic [MSW-1:0] sel_i,
`endif
  input  logic [BW-1:0]  cur_i,
  input  logic           first_i,
  output logic [BW-1:0]  nxt_o,
  output logic           last_o
);

  localparam int RATIO = MSW / SSW;

  logic [RATIO-1:0] iss;
  int               start;

`ifdef QMEM_WB_SKIP_EN
  always_comb begin
    iss = '0;
    for (int i = 0; i < RATIO; i++) begin
      iss[i] = |sel_i[MSW-1-i*SSW -: SSW];
    end
  end
`else
  assign iss = '1;
`endif

  // Lowest issued beat at or after the search start; last_o means none left.
  always_comb begin
    start  = first_i ? 0 : int'(cur_i) + 1;
    nxt_o  = '0;
    last_o = 1'b1;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (i >= start && iss[i]) begin
        nxt_o  = BW'(i);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/qmem_width_bridge.sv
// Single-clock QMEM downsizing bridge: one MDW master access becomes up to
// MDW/SDW slave beats, MS lane first. Optional beat skipping: QMEM_WB_SKIP_EN.
module qmem_width_bridge
  import qmem_pkg::*;
#(
  parameter int MAW = 22,
  parameter int MDW = 32,
  parameter int SDW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAW-1:0]   m_adr,
  input  logic             m_cs,
  input  logic             m_we,
  input  logic [MDW/8-1:0] m_sel,
  input  logic [MDW-1:0]   m_dat_w,
  output logic [MDW-1:0]   m_dat_r,
  output logic             m_ack,
  output logic             m_err,
  output logic [MAW-1:0]   s_adr,
  output logic             s_cs,
  output logic             s_we,
  output logic [SDW/8-1:0] s_sel,
  output logic [SDW-1:0]   s_dat_w,
  input  logic [SDW-1:0]   s_dat_r,
  input  logic             s_ack,
  input  logic             s_err
);

  localparam int RATIO = MDW / SDW;
  localparam int MSW   = MDW / 8;
  localparam int SSW   = SDW / 8;
  localparam int BW    = (clog2(RATIO) < 1) ? 1 : clog2(RATIO);
  localparam int MLSB  = clog2(MSW);
  localparam int SLSB  = clog2(SSW);

  function automatic logic [MAW-1:0] lane_adr(input logic [MAW-1:0] a, input logic [BW-1:0] k);
    logic [MAW-1:0] base;
    base = (a >> MLSB) << MLSB;
    return base | (MAW'(k) << SLSB);
  endfunction

  function automatic logic [SSW-1:0] lane_sel(input logic [MSW-1:0] s, input logic [BW-1:0] k);
    return s[MSW-1-int'(k)*SSW -: SSW];
  endfunction

  function automatic logic [SDW-1:0] lane_dat(input logic [MDW-1:0] d, input logic [BW-1:0] k);
    return d[MDW-1-int'(k)*SDW -: SDW];
  endfunction

  function automatic logic [MDW-1:0] put_lane(input logic [MDW-1:0] d, input logic [BW-1:0] k,
                                              input logic [SDW-1:0] v);
    logic [MDW-1:0] r;
    r = d;
    r[MDW-1-int'(k)*SDW -: SDW] = v;
    return r;
  endfunction

  qmem_state_e    state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [MAW-1:0] adr_q, adr_d;
  logic [MSW-1:0] sel_q, sel_d;
  logic [MDW-1:0] dat_q, dat_d;
  logic [MAW-1:0] s_adr_q, s_adr_d;
  logic           s_cs_q, s_cs_d;
  logic           s_we_q, s_we_d;
  logic [SSW-1:0] s_sel_q, s_sel_d;
  logic [SDW-1:0] s_dat_w_q, s_dat_w_d;
  logic [MDW-1:0] m_dat_r_q, m_dat_r_d;
  logic           m_ack_q, m_ack_d;
  logic           m_err_q, m_err_d;

  logic [BW-1:0]  bs_nxt;
  logic           bs_last;

`ifdef QMEM_WB_SKIP_EN
  // In IDLE the request is not latched yet, so search the live byte enables.
  logic [MSW-1:0] bs_sel;
  assign bs_sel = (state_q == ST_IDLE) ? m_sel : sel_q;
`endif

  qmem_beat_sel #(
    .MSW (MSW),
    .SSW (SSW),
    .BW  (BW)
  ) u_beat_sel (
`ifdef QMEM_WB_SKIP_EN
    .sel_i   (bs_sel),
`endif
    .cur_i   (beat_q),
    .first_i (state_q == ST_IDLE),
    .nxt_o   (bs_nxt),
    .last_o  (bs_last)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    s_adr_d   = s_adr_q;
    s_cs_d    = s_cs_q;
    s_we_d    = s_we_q;
    s_sel_d   = s_sel_q;
    s_dat_w_d = s_dat_w_q;
    m_dat_r_d = m_dat_r_q;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_cs) begin
          adr_d     = m_adr;
          sel_d     = m_sel;
          dat_d     = m_dat_w;
          s_we_d    = m_we;
          m_dat_r_d = '0;
          if (bs_last) begin
            state_d = ST_ACK;
            m_ack_d = 1'b1;
          end else begin
            beat_d    = bs_nxt;
            s_adr_d   = lane_adr(m_adr, bs_nxt);
            s_sel_d   = lane_sel(m_sel, bs_nxt);
            s_dat_w_d = lane_dat(m_dat_w, bs_nxt);
            s_cs_d    = 1'b1;
            state_d   = ST_BEAT;
          end
        end
      end
      ST_BEAT: begin
        if (s_ack) begin
          s_cs_d = 1'b0;
          if (!s_we_q) m_dat_r_d = put_lane(m_dat_r_q, beat_q, s_dat_r);
          // A slave error aborts the access; later lanes keep their cleared value.
          if (s_err) begin
            state_d = ST_ACK;
            m_ack_d = 1'b1;
            m_err_d = 1'b1;
          end else if (!bs_last) begin
            beat_d  = bs_nxt;
            state_d = ST_GAP;
          end else begin
            state_d = ST_ACK;
            m_ack_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        s_adr_d   = lane_adr(adr_q, beat_q);
        s_sel_d   = lane_sel(sel_q, beat_q);
        s_dat_w_d = lane_dat(dat_q, beat_q);
        s_cs_d    = 1'b1;
        state_d   = ST_BEAT;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      s_adr_q   <= '0;
      s_cs_q    <= 1'b0;
      s_we_q    <= 1'b0;
      s_sel_q   <= '0;
      s_dat_w_q <= '0;
      m_dat_r_q <= '0;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      s_adr_q   <= s_adr_d;
      s_cs_q    <= s_cs_d;
      s_we_q    <= s_we_d;
      s_sel_q   <= s_sel_d;
      s_dat_w_q <= s_dat_w_d;
      m_dat_r_q <= m_dat_r_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
    end
  end

  assign s_adr   = s_adr_q;
  assign s_cs    = s_cs_q;
  assign s_we    = s_we_q;
  assign s_sel   = s_sel_q;
  assign s_dat_w = s_dat_w_q;
  assign m_dat_r = m_dat_r_q;
  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;

endmodule
